// File: rtl/axis_video_frame_src.sv
// AXI4-Stream YUV 4:2:2 video frame source: 8-bar colour bars, one pixel per clock, tuser=SOF, tlast=EOL.
// Optional build macro VSRC_RAMP_PATTERN_EN adds cfg_pattern and an x^y luma ramp pattern.
module axis_video_frame_src #(
    parameter int MAX_DIM  = 4096,
    parameter int HBLANK_W = 8,
    parameter int VBLANK_W = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                enable,
    input  logic [15:0]         cfg_width,
    input  logic [15:0]         cfg_height,
    input  logic [HBLANK_W-1:0] cfg_hblank,
    input  logic [VBLANK_W-1:0] cfg_vblank,
    output logic [15:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                cfg_err
`ifdef VSRC_RAMP_PATTERN_EN
    ,
    input  logic                cfg_pattern
`endif
);
    localparam int CW = $clog2(MAX_DIM + 1);
    localparam int BW = (HBLANK_W > VBLANK_W) ? HBLANK_W : VBLANK_W;
    localparam logic [16:0] MAX_DIM_L = 17'(MAX_DIM);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VBLANK = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  width_r, width_s, height_r, height_s, barw_r, barw_s;
    logic [BW-1:0]  hblank_r, hblank_s, vblank_r, vblank_s, blank_r, blank_s;
    logic           pattern_r, pattern_s;
    logic [CW-1:0]  x_r, x_s, y_r, y_s, bcnt_r, bcnt_s;
    logic [2:0]     bar_r, bar_s;
    logic [15:0]    frame_r, frame_s;
    logic           err_r, err_s, busy_r, busy_s;
    logic           tvalid_r, tvalid_s, tuser_r, tuser_s, tlast_r, tlast_s;
    logic [15:0]    tdata_r, tdata_s;
    logic           load_s;
    logic           legal_s;
    logic           pattern_in_s;

    // Pixel value for a bar index / position; chroma alternates Cb (even x) and Cr (odd x).
    function automatic logic [15:0] pixel(input logic [2:0] bar, input logic [7:0] px,
                                          input logic [7:0] py, input logic ramp);
        logic [7:0] yv, cb, cr;
        case (bar)
            3'd0:    begin yv = 8'd235; cb = 8'd128; cr = 8'd128; end
            3'd1:    begin yv = 8'd210; cb = 8'd16;  cr = 8'd146; end
            3'd2:    begin yv = 8'd170; cb = 8'd166; cr = 8'd16;  end
            3'd3:    begin yv = 8'd145; cb = 8'd54;  cr = 8'd34;  end
            3'd4:    begin yv = 8'd106; cb = 8'd202; cr = 8'd222; end
            3'd5:    begin yv = 8'd81;  cb = 8'd90;  cr = 8'd240; end
            3'd6:    begin yv = 8'd41;  cb = 8'd240; cr = 8'd110; end
            default: begin yv = 8'd16;  cb = 8'd128; cr = 8'd128; end
        endcase
        return ramp ? {8'd128, px ^ py} : {(px[0] ? cr : cb), yv};
    endfunction

`ifdef VSRC_RAMP_PATTERN_EN
    assign pattern_in_s = cfg_pattern;
`else
    assign pattern_in_s = 1'b0;
`endif

    assign legal_s = (cfg_width[0] == 1'b0) && (cfg_width >= 16'd2) && (cfg_height >= 16'd1) &&
                     ({1'b0, cfg_width} <= MAX_DIM_L) && ({1'b0, cfg_height} <= MAX_DIM_L);

    // Next-state and next-register values for the whole generator.
    always_comb begin
        state_s   = state_r;
        width_s   = width_r;
        height_s  = height_r;
        barw_s    = barw_r;
        hblank_s  = hblank_r;
        vblank_s  = vblank_r;
        pattern_s = pattern_r;
        x_s       = x_r;
        y_s       = y_r;
        bcnt_s    = bcnt_r;
        bar_s     = bar_r;
        blank_s   = blank_r;
        frame_s   = frame_r;
        err_s     = err_r;
        tvalid_s  = tvalid_r;
        tdata_s   = tdata_r;
        tuser_s   = tuser_r;
        tlast_s   = tlast_r;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                width_s   = cfg_width[CW-1:0];
                height_s  = cfg_height[CW-1:0];
                hblank_s  = BW'(cfg_hblank);
                vblank_s  = BW'(cfg_vblank);
                pattern_s = pattern_in_s;
                barw_s    = (cfg_width[CW-1:3] == {(CW-3){1'b0}}) ? CW'(1) : CW'(cfg_width[CW-1:3]);
                if (legal_s) begin
                    err_s   = 1'b0;
                    state_s = ST_START;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                x_s      = {CW{1'b0}};
                y_s      = {CW{1'b0}};
                bcnt_s   = {CW{1'b0}};
                bar_s    = 3'd0;
                tvalid_s = 1'b1;
                load_s   = 1'b1;
                state_s  = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (m_axis_tready) begin
                    if (x_r == width_r - CW'(1)) begin
                        x_s     = {CW{1'b0}};
                        bcnt_s  = {CW{1'b0}};
                        bar_s   = 3'd0;
                        blank_s = {BW{1'b0}};
                        if (y_r == height_r - CW'(1)) begin
                            y_s      = {CW{1'b0}};
                            frame_s  = frame_r + 16'd1;
                            tvalid_s = 1'b0;
                            if (vblank_r != {BW{1'b0}}) begin
                                state_s = ST_VBLANK;
                            end else if (enable) begin
                                state_s = ST_LOAD;
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end else begin
                            y_s = y_r + CW'(1);
                            if (hblank_r != {BW{1'b0}}) begin
                                tvalid_s = 1'b0;
                                state_s  = ST_HBLANK;
                            end else begin
                                load_s = 1'b1;
                            end
                        end
                    end else begin
                        x_s    = x_r + CW'(1);
                        load_s = 1'b1;
                        // Bar index steps every barw pixels and saturates on the last bar.
                        if (bcnt_r == barw_r - CW'(1)) begin
                            bcnt_s = {CW{1'b0}};
                            bar_s  = (bar_r != 3'd7) ? bar_r + 3'd1 : bar_r;
                        end else begin
                            bcnt_s = bcnt_r + CW'(1);
                        end
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_HBLANK: begin
                if (blank_r == hblank_r - BW'(1)) begin
                    blank_s  = {BW{1'b0}};
                    tvalid_s = 1'b1;
                    load_s   = 1'b1;
                    state_s  = ST_ACTIVE;
                end else begin
                    blank_s = blank_r + BW'(1);
                end
            end
            ST_VBLANK: begin
                if (blank_r == vblank_r - BW'(1)) begin
                    blank_s = {BW{1'b0}};
                    if (enable) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    blank_s = blank_r + BW'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
            end
        endcase
        if (load_s) begin
            tdata_s = pixel(bar_s, x_s[7:0], y_s[7:0], pattern_s);
            tuser_s = (x_s == {CW{1'b0}}) && (y_s == {CW{1'b0}});
            tlast_s = (x_s == width_s - CW'(1));
        end else if (!tvalid_s) begin
            tdata_s = 16'h0000;
            tuser_s = 1'b0;
            tlast_s = 1'b0;
        end else begin
            tdata_s = tdata_r;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r   <= ST_IDLE;
            width_r   <= {CW{1'b0}};
            height_r  <= {CW{1'b0}};
            barw_r    <= {CW{1'b0}};
            hblank_r  <= {BW{1'b0}};
            vblank_r  <= {BW{1'b0}};
            pattern_r <= 1'b0;
            x_r       <= {CW{1'b0}};
            y_r       <= {CW{1'b0}};
            bcnt_r    <= {CW{1'b0}};
            bar_r     <= 3'd0;
            blank_r   <= {BW{1'b0}};
            frame_r   <= 16'd0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            tvalid_r  <= 1'b0;
            tdata_r   <= 16'h0000;
            tuser_r   <= 1'b0;
            tlast_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            width_r   <= width_s;
            height_r  <= height_s;
            barw_r    <= barw_s;
            hblank_r  <= hblank_s;
            vblank_r  <= vblank_s;
            pattern_r <= pattern_s;
            x_r       <= x_s;
            y_r       <= y_s;
            bcnt_r    <= bcnt_s;
            bar_r     <= bar_s;
            blank_r   <= blank_s;
            frame_r   <= frame_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
            tvalid_r  <= tvalid_s;
            tdata_r   <= tdata_s;
            tuser_r   <= tuser_s;
            tlast_r   <= tlast_s;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tuser  = tuser_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign frame_cnt     = frame_r;
    assign cfg_err       = err_r;

endmodule

// File: tb/tb_axis_video_frame_src.sv
// Scoreboard bench for axis_video_frame_src: a frame-level model queues expected beats and blanking gaps,
// a negedge monitor pops and compares every accepted beat while tready is randomised.
module tb_axis_video_frame_src;
    logic        aclk;
    logic        areset;
    logic        enable;
    logic [15:0] cfg_width, cfg_height;
    logic [7:0]  cfg_hblank;
    logic [15:0] cfg_vblank;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic        busy, cfg_err;
    logic [15:0] frame_cnt;
`ifdef VSRC_RAMP_PATTERN_EN
    logic        cfg_pattern;
`endif

    axis_video_frame_src dut (
        .aclk(aclk), .areset(areset), .enable(enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
`ifdef VSRC_RAMP_PATTERN_EN
        , .cfg_pattern(cfg_pattern)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int exp_frames = 0;
    int sof_seen = 0;
    logic [17:0] exp_q[$];
    int gap_q[$];
    int y_tab[8]  = '{235, 210, 170, 145, 106, 81, 41, 16};
    int cb_tab[8] = '{128, 16, 166, 54, 202, 90, 240, 128};
    int cr_tab[8] = '{128, 146, 16, 34, 222, 240, 110, 128};

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole frames of {chroma, luma, sof, eol} plus the idle gap after every line.
    task automatic push_frames(int w, int h, int hb, int vb, int nf, bit ramp);
        int bw, bar, yv, c;
        bw = (w / 8 == 0) ? 1 : w / 8;
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    bar = (x / bw > 7) ? 7 : x / bw;
                    yv  = ramp ? ((x ^ y) & 255) : y_tab[bar];
                    c   = ramp ? 128 : ((x % 2 == 0) ? cb_tab[bar] : cr_tab[bar]);
                    exp_q.push_back({8'(c), 8'(yv), (x == 0 && y == 0), (x == w - 1)});
                    if (x == w - 1)
                        gap_q.push_back((y < h - 1) ? hb : ((f < nf - 1) ? vb + 2 : -1));
                end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    logic [17:0] cur, held, e;
    bit stall_pend = 0;
    bit gap_active = 0;
    int gap_cnt = 0;
    int gap_exp = -1;
    assign cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast};

    // Monitor: stall stability, blanking gap length and scoreboard pop on every accepted beat.
    always @(negedge aclk) begin
        if (areset) begin
            stall_pend = 0;
            gap_active = 0;
        end else begin
            if (gap_active) begin
                if (m_axis_tvalid) begin
                    gap_active = 0;
                    if (gap_exp >= 0) check("blank_gap", gap_cnt, gap_exp);
                end else begin
                    gap_cnt++;
                end
            end
            if (stall_pend) check("stall_hold", 32'({m_axis_tvalid, cur}), 32'({1'b1, held}));
            stall_pend = m_axis_tvalid && !m_axis_tready;
            held = cur;
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat", 32'(cur), 32'(e));
                end
                if (m_axis_tlast) begin
                    gap_exp = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
                    gap_active = 1;
                    gap_cnt = 0;
                end
                if (m_axis_tuser) sof_seen++;
            end
        end
    end

    task automatic run_frames(int w, int h, int hb, int vb, int nf, bit ramp, int rmode);
        int tgt, n;
        @(posedge aclk);
        #1;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        cfg_hblank = 8'(hb);
        cfg_vblank = 16'(vb);
`ifdef VSRC_RAMP_PATTERN_EN
        cfg_pattern = ramp;
`endif
        rdy_mode = rmode;
        push_frames(w, h, hb, vb, nf, ramp);
        tgt = sof_seen + nf;
        enable = 1'b1;
        @(posedge aclk); #1;
        check("lat_load_tvalid", 32'(m_axis_tvalid), 0);
        check("busy_on", 32'(busy), 1);
        @(posedge aclk); #1;
        check("lat_e1_tvalid", 32'(m_axis_tvalid), 0);
        @(posedge aclk); #1;
        check("lat_e2_tvalid", 32'(m_axis_tvalid), 1);
        check("first_tdata", 32'(m_axis_tdata), ramp ? 32'h8000 : 32'h80EB);
        n = 0;
        while (sof_seen < tgt && n < 20000) begin
            @(posedge aclk); #1;
            n++;
        end
        check("sof_count", sof_seen, tgt);
        enable = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            @(posedge aclk); #1;
            n++;
        end
        check("busy_idle", 32'(busy), 0);
        exp_frames = (exp_frames + nf) & 32'hFFFF;
        @(negedge aclk); #1;
        check("frame_cnt", 32'(frame_cnt), exp_frames);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        exp_q.delete();
        gap_q.delete();
        exp_frames = 0;
        areset = 1'b0;
    endtask

    initial begin
        int w, h, hb, vb, nf;
        enable = 1'b0;
        cfg_width = 16'd0; cfg_height = 16'd0; cfg_hblank = 8'd0; cfg_vblank = 16'd0;
`ifdef VSRC_RAMP_PATTERN_EN
        cfg_pattern = 1'b0;
`endif
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_outputs", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, cfg_err}), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        do_reset();

        // Two back-to-back frames with no blanking, then ramp up stalls on a 16x2 frame.
        run_frames(48, 40, 0, 0, 2, 1'b0, 0);
        run_frames(16, 2, 0, 0, 1, 1'b0, 1);

        // Illegal odd width: error flag, no beats, back to idle.
        @(posedge aclk); #1;
        cfg_width = 16'd15; cfg_height = 16'd4;
        enable = 1'b1;
        @(posedge aclk); #1;
        enable = 1'b0;
        check("err_load_busy", 32'(busy), 1);
        @(posedge aclk); #1;
        check("cfg_err_set", 32'(cfg_err), 1);
        check("err_busy_clear", 32'(busy), 0);
        repeat (5) @(posedge aclk);
        #1;
        check("err_no_tvalid", 32'(m_axis_tvalid), 0);
        check("cfg_err_sticky", 32'(cfg_err), 1);
        run_frames(16, 4, 0, 0, 1, 1'b0, 0);
        check("cfg_err_cleared", 32'(cfg_err), 0);

        run_frames(8, 3, 5, 10, 2, 1'b0, 0);

        do_reset();
        run_frames(32, 8, 3, 2, 1, 1'b0, 1);

        // Asynchronous reset in the middle of a frame.
        @(posedge aclk); #1;
        cfg_width = 16'd32; cfg_height = 16'd8; cfg_hblank = 8'd0; cfg_vblank = 16'd0;
        rdy_mode = 0;
        push_frames(32, 8, 0, 0, 1, 1'b0);
        enable = 1'b1;
        repeat (100) @(posedge aclk);
        #1;
        check("pre_reset_tvalid", 32'(m_axis_tvalid), 1);
        #2;
        areset = 1'b1;
        #1;
        check("async_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 0);
        check("async_rst_busy", 32'(busy), 0);
        enable = 1'b0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            w  = 2 * $urandom_range(1, 20);
            h  = $urandom_range(1, 4);
            hb = $urandom_range(0, 3);
            vb = $urandom_range(0, 4);
            nf = $urandom_range(1, 2);
            run_frames(w, h, hb, vb, nf, 1'b0, 1);
        end

`ifdef VSRC_RAMP_PATTERN_EN
        run_frames(8, 2, 0, 0, 1, 1'b1, 0);
        run_frames(8, 2, 1, 1, 1, 1'b1, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
